rpp_header_deframer: RTL and testbench

Byte-stream front end for the spiral routing core. Accepts an 8-bit valid/ready byte stream, checks each frame's magic byte, and assembles an 18-byte RPP header plus a 4-byte destination address. It presents them as `header_out`/`dest_address` with a level `header_valid` that is held until the downstream routing core acknowledges. It also detects framing errors and inter-byte timeouts.

---
 rtl/rpp_header_deframer.sv | 163 ++++++++++++++++
 tb/tb_rpp_header_deframer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpp_header_deframer.sv
// Byte-stream deframer: checks the frame magic byte, assembles an RPP header plus destination
// address, and holds them for the routing core until acknowledged. Flags sync, framing and
// inter-byte timeout errors as single-cycle pulses.
module rpp_header_deframer #(
  parameter int unsigned HEADER_BYTES   = 18,
  parameter int unsigned DEST_BYTES     = 4,
  parameter logic [7:0]  MAGIC          = 8'h42,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                byte_in,
  input  logic                      byte_valid,
  input  logic                      byte_sof,
  output logic                      byte_ready,
  output logic [8*HEADER_BYTES-1:0] header_out,
  output logic [8*DEST_BYTES-1:0]   dest_address,
  output logic                      header_valid,
  input  logic                      header_ack,
  output logic                      sync_err,
  output logic                      frame_err,
  output logic                      timeout_err,
  output logic [15:0]               frame_count
);

  localparam int unsigned HdrW = 8 * HEADER_BYTES;
  localparam int unsigned DstW = 8 * DEST_BYTES;
  localparam int unsigned CntW = $clog2(HEADER_BYTES + 1);

  typedef enum logic [1:0] {StIdle, StHdr, StDest, StHold} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [7:0]        idle_cnt_q, idle_cnt_d;
  logic [HdrW-1:0]   hdr_shadow_q, hdr_shadow_d;
  logic [DstW-1:0]   dst_shadow_q, dst_shadow_d;
  logic [HdrW-1:0]   header_out_q, header_out_d;
  logic [DstW-1:0]   dest_address_q, dest_address_d;
  logic              header_valid_q, header_valid_d;
  logic              sync_err_q, sync_err_d;
  logic              frame_err_q, frame_err_d;
  logic              timeout_err_q, timeout_err_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic              accept;

  // Ready is a pure decode of the registered state.
  assign byte_ready   = (state_q != StHold);
  assign accept       = byte_valid && byte_ready;
  assign header_out   = header_out_q;
  assign dest_address = dest_address_q;
  assign header_valid = header_valid_q;
  assign sync_err     = sync_err_q;
  assign frame_err    = frame_err_q;
  assign timeout_err  = timeout_err_q;
  assign frame_count  = frame_count_q;

  // Next-state logic: frame assembly, SOF restart, timeout and hold/ack handshake.
  always_comb begin
    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    idle_cnt_d     = idle_cnt_q;
    hdr_shadow_d   = hdr_shadow_q;
    dst_shadow_d   = dst_shadow_q;
    header_out_d   = header_out_q;
    dest_address_d = dest_address_q;
    header_valid_d = header_valid_q;
    sync_err_d     = 1'b0;
    frame_err_d    = 1'b0;
    timeout_err_d  = 1'b0;
    frame_count_d  = frame_count_q;

    unique case (state_q)
      StHold: begin
        if (header_ack) begin
          header_valid_d = 1'b0;
          state_d        = StIdle;
        end
      end
      default: begin
        if (accept && byte_sof) begin
          // SOF always (re)starts framing; mid-frame it also abandons the partial frame.
          frame_err_d = (state_q != StIdle);
          idle_cnt_d  = '0;
          byte_cnt_d  = '0;
          if (byte_in == MAGIC) begin
            hdr_shadow_d = {hdr_shadow_q[HdrW-9:0], byte_in};
            byte_cnt_d   = CntW'(1);
            state_d      = StHdr;
          end else begin
            sync_err_d = 1'b1;
            state_d    = StIdle;
          end
        end else if (state_q == StIdle) begin
          // Non-SOF bytes outside a frame are dropped.
          idle_cnt_d = '0;
        end else if (accept) begin
          idle_cnt_d = '0;
          if (state_q == StHdr) begin
            hdr_shadow_d = {hdr_shadow_q[HdrW-9:0], byte_in};
            if (byte_cnt_q == CntW'(HEADER_BYTES - 1)) begin
              byte_cnt_d = '0;
              state_d    = StDest;
            end else begin
              byte_cnt_d = byte_cnt_q + CntW'(1);
            end
          end else begin
            dst_shadow_d = {dst_shadow_q[DstW-9:0], byte_in};
            if (byte_cnt_q == CntW'(DEST_BYTES - 1)) begin
              header_out_d   = hdr_shadow_q;
              dest_address_d = {dst_shadow_q[DstW-9:0], byte_in};
              header_valid_d = 1'b1;
              frame_count_d  = frame_count_q + 16'd1;
              byte_cnt_d     = '0;
              state_d        = StHold;
            end else begin
              byte_cnt_d = byte_cnt_q + CntW'(1);
            end
          end
        end else if (idle_cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          // Counter would reach the limit on this edge with no byte arriving.
          timeout_err_d = 1'b1;
          idle_cnt_d    = '0;
          byte_cnt_d    = '0;
          state_d       = StIdle;
        end else begin
          idle_cnt_d = idle_cnt_q + 8'd1;
        end
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      byte_cnt_q     <= '0;
      idle_cnt_q     <= '0;
      hdr_shadow_q   <= '0;
      dst_shadow_q   <= '0;
      header_out_q   <= '0;
      dest_address_q <= '0;
      header_valid_q <= 1'b0;
      sync_err_q     <= 1'b0;
      frame_err_q    <= 1'b0;
      timeout_err_q  <= 1'b0;
      frame_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      byte_cnt_q     <= byte_cnt_d;
      idle_cnt_q     <= idle_cnt_d;
      hdr_shadow_q   <= hdr_shadow_d;
      dst_shadow_q   <= dst_shadow_d;
      header_out_q   <= header_out_d;
      dest_address_q <= dest_address_d;
      header_valid_q <= header_valid_d;
      sync_err_q     <= sync_err_d;
      frame_err_q    <= frame_err_d;
      timeout_err_q  <= timeout_err_d;
      frame_count_q  <= frame_count_d;
    end
  end

endmodule

// File: tb/tb_rpp_header_deframer.sv
// Directed self-checking bench for rpp_header_deframer.
module tb_rpp_header_deframer;

  logic         clk;
  logic         rst_n;
  logic [7:0]   byte_in;
  logic         byte_valid;
  logic         byte_sof;
  logic         byte_ready;
  logic [143:0] header_out;
  logic [31:0]  dest_address;
  logic         header_valid;
  logic         header_ack;
  logic         sync_err;
  logic         frame_err;
  logic         timeout_err;
  logic [15:0]  frame_count;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] tv1 [22] = '{8'h42, 8'h58, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00,
                           8'h10, 8'hF0, 8'h2B, 8'h01, 8'h2A, 8'h00, 8'h42, 8'h00, 8'h00,
                           8'h52, 8'h68, 8'h00, 8'h00};
  logic [7:0] tv2 [22] = '{8'h42, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                           8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h01, 8'h02,
                           8'hDE, 8'hAD, 8'hBE, 8'hEF};
  localparam logic [143:0] Tv1Hdr = 144'h42580000_00000001_0010_F0_2B_01_2A_0042_00_00;
  localparam logic [31:0]  Tv1Dst = 32'h52680000;
  localparam logic [143:0] Tv2Hdr = 144'h42112233_44556677_8899AABB_CCDDEEFF_0102;
  localparam logic [31:0]  Tv2Dst = 32'hDEADBEEF;

  logic [15:0] exp_cnt;

  rpp_header_deframer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_sof    (byte_sof),
    .byte_ready  (byte_ready),
    .header_out  (header_out),
    .dest_address(dest_address),
    .header_valid(header_valid),
    .header_ack  (header_ack),
    .sync_err    (sync_err),
    .frame_err   (frame_err),
    .timeout_err (timeout_err),
    .frame_count (frame_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Called at a negedge; returns at the following negedge after the byte's edge.
  task automatic send_byte(input logic [7:0] b, input logic sof);
    byte_in    = b;
    byte_sof   = sof;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
    byte_sof   = 1'b0;
  endtask

  task automatic send_tv(input int which, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      send_byte((which == 1) ? tv1[i] : tv2[i], i == 0);
    end
  endtask

  task automatic do_ack();
    header_ack = 1'b1;
    @(negedge clk);
    header_ack = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (byte_ready !== 1'b1 || header_valid !== 1'b0 || frame_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready=%b valid=%b count=%0d required 1 0 0",
               byte_ready, header_valid, frame_count);
    end
    n_cmp++;
    if (header_out !== 144'd0 || dest_address !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_data: hdr=%h dst=%h required zero", header_out, dest_address);
    end
    n_cmp++;
    if ({sync_err, frame_err, timeout_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_err: errs=%b required 000", {sync_err, frame_err, timeout_err});
    end
  endtask

  task automatic test_nominal();
    send_tv(1, 0, 21);
    exp_cnt = exp_cnt + 16'd1;
    n_cmp++;
    if (header_valid !== 1'b1 || byte_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL nominal_ctrl: valid=%b ready=%b required 1 0", header_valid, byte_ready);
    end
    n_cmp++;
    if (header_out !== Tv1Hdr || dest_address !== Tv1Dst) begin
      n_fail++;
      $display("FAIL nominal_data: hdr=%h dst=%h required %h %h",
               header_out, dest_address, Tv1Hdr, Tv1Dst);
    end
    n_cmp++;
    if (frame_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL nominal_count: got %0d required %0d", frame_count, exp_cnt);
    end
  endtask

  task automatic test_ack();
    int bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (header_valid !== 1'b1 || byte_ready !== 1'b0 || header_out !== Tv1Hdr ||
          dest_address !== Tv1Dst) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL ack_hold: %0d unstable cycles, required 0", bad);
    end
    do_ack();
    n_cmp++;
    if (header_valid !== 1'b0 || byte_ready !== 1'b1 || frame_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL ack_release: valid=%b ready=%b count=%0d required 0 1 %0d",
               header_valid, byte_ready, frame_count, exp_cnt);
    end
  endtask

  task automatic test_sync_err();
    send_byte(8'h43, 1'b1);
    n_cmp++;
    if (sync_err !== 1'b1 || frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL sync_pulse: sync=%b frame=%b required 1 0", sync_err, frame_err);
    end
    send_byte(8'h42, 1'b0);
    n_cmp++;
    if (sync_err !== 1'b0 || frame_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL sync_once: sync=%b count=%0d required 0 %0d", sync_err, frame_count, exp_cnt);
    end
    // Had the non-SOF 0x42 opened a frame, this SOF would flag a framing error.
    send_byte(tv2[0], 1'b1);
    n_cmp++;
    if (frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL sync_ignore: frame_err=%b required 0", frame_err);
    end
    send_tv(2, 1, 21);
    exp_cnt = exp_cnt + 16'd1;
    n_cmp++;
    if (header_out !== Tv2Hdr || dest_address !== Tv2Dst || frame_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL sync_recover: hdr=%h dst=%h count=%0d required %h %h %0d",
               header_out, dest_address, frame_count, Tv2Hdr, Tv2Dst, exp_cnt);
    end
    do_ack();
  endtask

  task automatic test_frame_err();
    send_tv(1, 0, 9);
    send_byte(tv2[0], 1'b1);
    n_cmp++;
    if (frame_err !== 1'b1 || sync_err !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_pulse: frame=%b sync=%b required 1 0", frame_err, sync_err);
    end
    send_byte(tv2[1], 1'b0);
    n_cmp++;
    if (frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_once: frame=%b required 0", frame_err);
    end
    send_tv(2, 2, 21);
    exp_cnt = exp_cnt + 16'd1;
    n_cmp++;
    if (header_out !== Tv2Hdr || dest_address !== Tv2Dst || frame_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL frame_second: hdr=%h dst=%h count=%0d required %h %h %0d",
               header_out, dest_address, frame_count, Tv2Hdr, Tv2Dst, exp_cnt);
    end
    do_ack();
  endtask

  task automatic test_timeout();
    int early = 0;
    send_tv(1, 0, 4);
    for (int k = 1; k <= 254; k++) begin
      @(negedge clk);
      if (timeout_err !== 1'b0) early++;
    end
    @(negedge clk);
    n_cmp++;
    if (early != 0 || timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_255: early=%0d pulse=%b required 0 1", early, timeout_err);
    end
    @(negedge clk);
    n_cmp++;
    if (timeout_err !== 1'b0 || byte_ready !== 1'b1 || header_out !== Tv2Hdr ||
        dest_address !== Tv2Dst || frame_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL timeout_state: pulse=%b ready=%b hdr=%h count=%0d required 0 1 %h %0d",
               timeout_err, byte_ready, header_out, frame_count, Tv2Hdr, exp_cnt);
    end
    // 254-cycle gap: the byte arriving on the limit edge wins.
    early = 0;
    send_tv(1, 0, 4);
    for (int k = 1; k <= 254; k++) begin
      @(negedge clk);
      if (timeout_err !== 1'b0) early++;
    end
    send_tv(1, 5, 5);
    if (timeout_err !== 1'b0) early++;
    send_tv(1, 6, 21);
    exp_cnt = exp_cnt + 16'd1;
    n_cmp++;
    if (early != 0 || header_valid !== 1'b1 || header_out !== Tv1Hdr ||
        frame_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL timeout_254: pulses=%0d valid=%b hdr=%h count=%0d required 0 1 %h %0d",
               early, header_valid, header_out, frame_count, Tv1Hdr, exp_cnt);
    end
    do_ack();
  endtask

  task automatic test_back_to_back();
    header_ack = 1'b1;
    send_tv(2, 0, 21);
    exp_cnt = exp_cnt + 16'd1;
    n_cmp++;
    if (header_valid !== 1'b1 || byte_ready !== 1'b0 || header_out !== Tv2Hdr) begin
      n_fail++;
      $display("FAIL b2b_first: valid=%b ready=%b hdr=%h required 1 0 %h",
               header_valid, byte_ready, header_out, Tv2Hdr);
    end
    @(negedge clk);
    n_cmp++;
    if (header_valid !== 1'b0 || byte_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_release: valid=%b ready=%b required 0 1", header_valid, byte_ready);
    end
    send_tv(1, 0, 21);
    exp_cnt = exp_cnt + 16'd1;
    n_cmp++;
    if (header_valid !== 1'b1 || header_out !== Tv1Hdr || frame_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL b2b_second: valid=%b hdr=%h count=%0d required 1 %h %0d",
               header_valid, header_out, frame_count, Tv1Hdr, exp_cnt);
    end
    @(negedge clk);
    header_ack = 1'b0;
  endtask

  task automatic test_reset_wrap();
    send_tv(2, 0, 11);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (header_out !== 144'd0 || dest_address !== 32'd0 || header_valid !== 1'b0 ||
        frame_count !== 16'd0 || byte_ready !== 1'b1 ||
        {sync_err, frame_err, timeout_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_midframe: hdr=%h dst=%h valid=%b count=%0d ready=%b required 0 0 0 0 1",
               header_out, dest_address, header_valid, frame_count, byte_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // Remaining bytes of the interrupted frame must not be taken as a frame.
    send_tv(2, 12, 21);
    n_cmp++;
    if (header_valid !== 1'b0 || frame_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_discard: valid=%b count=%0d required 0 0", header_valid, frame_count);
    end
    force dut.frame_count_q = 16'hFFFF;
    @(negedge clk);
    @(negedge clk);
    release dut.frame_count_q;
    @(negedge clk);
    send_tv(1, 0, 21);
    n_cmp++;
    if (frame_count !== 16'h0000 || header_valid !== 1'b1 || header_out !== Tv1Hdr) begin
      n_fail++;
      $display("FAIL wrap: count=%h valid=%b hdr=%h required 0000 1 %h",
               frame_count, header_valid, header_out, Tv1Hdr);
    end
    do_ack();
  endtask

  initial begin
    rst_n      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    byte_sof   = 1'b0;
    header_ack = 1'b0;
    exp_cnt    = 16'd0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_nominal();
    test_ack();
    test_sync_err();
    test_frame_err();
    test_timeout();
    test_back_to_back();
    test_reset_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
